// File: rtl/rst_sequencer.sv
// Multi-channel reset sequencer: holds all downstream resets for a programmable time,
// then releases them one at a time in index order with a programmable gap between releases.
module rst_sequencer #(
    parameter int                     CHANNELS    = 4,
    parameter int                     HOLD_CYCLES = 16,
    parameter int                     STAGE_GAP   = 8,
    parameter int                     CNT_W       = 8,
    parameter logic [CHANNELS-1:0]    POLARITY    = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // A trigger always wins over any release scheduled for the same edge; idx names the
    // next channel to release once the hold period has released channel 0.
    always_ff @(posedge clk) begin
        if (rst || req) begin
            state   <= HOLD;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= POLARITY;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        rst_out[0] <= ~POLARITY[0];
                        if (CHANNELS == 1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= STAGE;
                            idx   <= IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STAGE: begin
                    if (cnt == GAP_LAST) begin
                        cnt          <= '0;
                        rst_out[idx] <= ~POLARITY[idx];
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    rst_out <= ~POLARITY;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: three parameterisations share one stimulus stream and are
// compared every cycle against an arithmetic model of the release schedule.
module tb_rst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [3:0] outA;
    logic [3:0] outP;
    logic [0:0] outO;
    logic       busyA, doneA, busyP, doneP, busyO, doneO;

    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;

    rst_sequencer u_dflt (
        .clk(clk), .rst(rst), .req(req), .rst_out(outA), .busy(busyA), .done(doneA)
    );

    rst_sequencer #(.POLARITY(4'b0101)) u_pol (
        .clk(clk), .rst(rst), .req(req), .rst_out(outP), .busy(busyP), .done(doneP)
    );

    rst_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .POLARITY(1'b1)) u_one (
        .clk(clk), .rst(rst), .req(req), .rst_out(outO), .busy(busyO), .done(doneO)
    );

    typedef struct {
        logic       rst;
        logic       req;
        int         ncyc;
        logic [3:0] expOut;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    vec_t vecs [8];

    // kk counts consecutive trigger-free edges; channel i is released once kk reaches
    // HOLD + i*GAP, and the last release is the done cycle.
    function automatic logic [5:0] modelOut(input int kk, input int c, input int h,
                                            input int g, input logic [3:0] pol);
        logic [3:0] o;
        int         last;
        o    = 4'b0000;
        last = h + (c - 1) * g;
        for (int i = 0; i < c; i++)
            o[i] = (kk > 0 && kk >= h + i * g) ? ~pol[i] : pol[i];
        return {(kk == 0) || (kk < last), (kk == last), o};
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic q);
        logic [5:0] e;
        rst = r;
        req = q;
        @(posedge clk);
        #1;
        if (r || q) k = 0;
        else if (k < 100000) k++;
        e = modelOut(k, 4, 16, 8, 4'b1111);
        checkOutput("dflt rst_out", outA, e[3:0]);
        checkOutput("dflt busy,done", {2'b00, busyA, doneA}, {2'b00, e[5:4]});
        e = modelOut(k, 4, 16, 8, 4'b0101);
        checkOutput("pol rst_out", outP, e[3:0]);
        checkOutput("pol busy,done", {2'b00, busyP, doneP}, {2'b00, e[5:4]});
        e = modelOut(k, 1, 1, 1, 4'b0001);
        checkOutput("one rst_out", {3'b000, outO}, e[3:0]);
        checkOutput("one busy,done", {2'b00, busyO, doneO}, {2'b00, e[5:4]});
    endtask

    initial begin
        int nt;
        int gap;
        logic r;
        logic q;

        vecs[0] = '{1'b1, 1'b0, 3,  4'b1111, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 15, 4'b1111, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1,  4'b1110, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 7,  4'b1110, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1,  4'b1100, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8,  4'b1000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < vecs[v].ncyc; c++)
                applyStimulus(vecs[v].rst, vecs[v].req);
            checkOutput($sformatf("table[%0d] rst_out", v), outA, vecs[v].expOut);
            checkOutput($sformatf("table[%0d] busy,done", v), {2'b00, busyA, doneA},
                        {2'b00, vecs[v].expBusy, vecs[v].expDone});
        end
        checkOutput("pol idle rst_out", outP, 4'b1010);

        // Mid-sequence req after ch0 and ch1 have released.
        applyStimulus(1'b1, 1'b0);
        repeat (28) applyStimulus(1'b0, 1'b0);
        checkOutput("midreq before", outA, 4'b1100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("midreq reassert", outA, 4'b1111);
        checkOutput("midreq done", {3'b000, doneA}, 4'b0000);
        repeat (15) applyStimulus(1'b0, 1'b0);
        checkOutput("midreq still held", outA, 4'b1111);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midreq ch0 release", outA, 4'b1110);

        // req held for 10 cycles while idle.
        repeat (45) applyStimulus(1'b0, 1'b0);
        checkOutput("idle before req", {3'b000, busyA}, 4'b0000);
        repeat (10) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("req held busy", {3'b000, busyA}, 4'b0001);
            checkOutput("req held pol", outP, 4'b0101);
        end
        repeat (16) applyStimulus(1'b0, 1'b0);
        checkOutput("req held restart", outA, 4'b1110);

        // rst during STAGE.
        applyStimulus(1'b1, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("stage rst rst_out", outA, 4'b1111);
        checkOutput("stage rst busy,done", {2'b00, busyA, doneA}, 4'b0010);
        repeat (40) applyStimulus(1'b0, 1'b0);
        checkOutput("stage rst rerun done", {2'b00, busyA, doneA}, 4'b0001);

        // Single-channel boundary: req on the release edge suppresses release and done.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("one suppressed", {2'b00, outO, doneO}, 4'b0010);
        applyStimulus(1'b0, 1'b0);
        checkOutput("one release", {2'b00, outO, doneO}, 4'b0001);
        applyStimulus(1'b0, 1'b0);
        checkOutput("one done pulse ends", {2'b00, outO, doneO}, 4'b0000);

        // Randomised trigger bursts separated by trigger-free gaps of random length.
        repeat (60) begin
            nt  = $urandom_range(1, 3);
            gap = $urandom_range(0, 55);
            for (int t = 0; t < nt; t++) begin
                r = 1'($urandom_range(0, 1));
                q = r ? 1'($urandom_range(0, 1)) : 1'b1;
                applyStimulus(r, q);
            end
            for (int t = 0; t < gap; t++)
                applyStimulus(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Synthesizable multi-channel reset sequencer that replaces ad-hoc reset tasks in benches and tops. After the global reset or a software request, it holds every downstream reset asserted for a programmable time. It then releases the channels one at a time, in index order, with a programmable gap between releases. It sits between the board/PLL-derived global reset and the per-domain reset inputs of datapath blocks. Output polarity is configurable per channel.

## Interface
- CHANNELS, 4: number of sequenced reset outputs (≥1)
- HOLD_CYCLES, 16: cycles all channels stay asserted after the trigger ends (≥1)
- STAGE_GAP, 8: cycles between successive channel releases (≥1)
- CNT_W, 8: internal counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, STAGE_GAP)
- POLARITY, {CHANNELS{1'b1}}: bit i = 1 means rst_out[i] is active-high; 0 means active-low
- clk  input  1  single clock; all logic on posedge
- rst  input  1  reset; synchronous, active-high
- req  input  1  software re-sequence request, sampled on posedge, active-high
- rst_out  output  CHANNELS  sequenced resets; asserted level of bit i = POLARITY[i]; registered
- busy  output  1  high while any channel is asserted; registered
- done  output  1  one-cycle pulse when the last channel releases; registered

## Operation
- States:
  - HOLD: all channels asserted; counter counts the hold time.
  - STAGE: channels release one by one; counter counts STAGE_GAP per channel; a channel index tracks the next channel to release.
  - IDLE: all channels deasserted.
- Trigger = rst OR req. A trigger sampled high at any edge, in any state, does all of the following at that edge:
  - forces state HOLD;
  - clears the counter and channel index;
  - sets rst_out = POLARITY (all channels asserted);
  - sets busy = 1 and done = 0.
- Trigger held high keeps the block in this condition. The sequence restarts whenever the trigger is seen again, so a mid-sequence req re-asserts channels that were already released.
- HOLD → STAGE after HOLD_CYCLES trigger-free edges. Channel 0 releases on the transition edge.
- STAGE: channel i releases STAGE_GAP edges after channel i-1. A released channel drives ~POLARITY[i].
- On the release of channel CHANNELS-1: state → IDLE, busy → 0, done → 1 for exactly one cycle.
- With CHANNELS = 1 the block goes HOLD → IDLE directly, with done on the channel 0 release.
- IDLE: outputs are static (rst_out = ~POLARITY, busy = 0, done = 0) until the next trigger.
- The counter never wraps. It is compared for equality against HOLD_CYCLES-1 or STAGE_GAP-1, then cleared.

## Timing
- Reset values (rst high at an edge): rst_out = POLARITY, busy = 1, done = 0.
- Let e0 be the first edge at which the trigger is sampled low after having been high.
- Channel i deasserts on edge e0 + HOLD_CYCLES - 1 + i·STAGE_GAP, visible in the following cycle.
- With defaults, visible release cycles relative to e0: ch0 +16, ch1 +24, ch2 +32, ch3 +40. busy falls and done pulses in cycle +40.
- A req pulse at edge er behaves exactly like a one-cycle rst at er, so e0 = er + 1.
- If rst and req are both high at the same edge, the result is identical to rst alone.
- A trigger arriving on the same edge as a scheduled release wins: nothing releases and no done pulse is produced.
- All outputs are glitch-free register outputs. There is no combinational path from req or rst to any output.

## Test plan
- Power-up, default params: rst high for 3 cycles, then low. rst_out = 4'b1111 until cycle e0+16. Then 4'b1110 at +16, 4'b1100 at +24, 4'b1000 at +32, 4'b0000 at +40. done high only in cycle +40; busy low from +40.
- Mixed polarity (POLARITY = 4'b0101): after rst, rst_out = 4'b0101 during hold; in IDLE, rst_out = 4'b1010.
- Mid-sequence req: one-cycle req pulse at e0+28, after ch0 and ch1 have released. rst_out returns to 4'b1111 the next cycle. ch0 then releases at e0+28+1+16 = e0+45 visible. No done pulse before that restarted sequence completes.
- req held high for 10 cycles while in IDLE: outputs stay asserted with busy = 1 throughout. The timeline restarts from the edge where req is first sampled low.
- Boundary: CHANNELS = 1, HOLD_CYCLES = 1, STAGE_GAP = 1. rst low at e0, then rst_out releases and done pulses in cycle e0+1. A req coinciding with that release edge suppresses both the release and done.
- rst asserted during STAGE, at e0+30: all outputs return to their reset values the next cycle, done stays 0, and the sequence re-runs with full timing.
